// File: rtl/mii_rx_frame_receiver.sv
// MII nibble-to-byte receiver: strips preamble/SFD, checks FCS/length, drops the FCS, flags bad frames.
// Payload byte out one cycle after the edge that completes the byte 5 positions later; no backpressure.
module mii_rx_frame_receiver #(
   parameter int P_MIN_FRAME_BYTES = 64,
   parameter int P_MAX_FRAME_BYTES = 1518
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [3:0]  i_rx_d,
   input  logic        i_rx_dv,
   input  logic        i_rx_er,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_last,
   output logic        o_error,
   output logic [15:0] o_frame_count,
   output logic [15:0] o_error_count
);

   localparam logic [31:0] LP_POLY    = 32'hEDB88320;
   localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] LP_MIN     = 11'(P_MIN_FRAME_BYTES);
   localparam logic [10:0] LP_MAX_P1  = 11'(P_MAX_FRAME_BYTES + 1);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

   state_t      r_state;
   logic [3:0]  r_low;
   logic        r_half;
   logic [7:0]  r_line [5];
   logic [2:0]  r_fill;
   logic [10:0] r_byte_cnt;
   logic [31:0] r_crc;
   logic        r_er;

   logic [7:0]  w_byte;
   logic [10:0] w_byte_cnt_nxt;
   logic        w_line_full;
   logic        w_bad_end;

   function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int k = 0; k < 8; k++)
         c = c[0] ? ((c >> 1) ^ LP_POLY) : (c >> 1);
      return c;
   endfunction

   assign w_byte         = {i_rx_d, r_low};
   assign w_byte_cnt_nxt = r_byte_cnt + 11'd1;
   assign w_line_full    = (r_fill == 3'd5);
   // Frames of 4 bytes or fewer never fill the line and are always counted as bad.
   assign w_bad_end      = r_er | r_half | (r_byte_cnt < LP_MIN) | (r_crc != LP_RESIDUE) | ~w_line_full;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_low         <= 4'h0;
         r_half        <= 1'b0;
         r_fill        <= 3'd0;
         r_byte_cnt    <= 11'd0;
         r_crc         <= 32'hFFFFFFFF;
         r_er          <= 1'b0;
         for (int i = 0; i < 5; i++)
            r_line[i] <= 8'h00;
         o_data        <= 8'h00;
         o_valid       <= 1'b0;
         o_last        <= 1'b0;
         o_error       <= 1'b0;
         o_frame_count <= 16'd0;
         o_error_count <= 16'd0;
      end else begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_rx_dv)
                  r_state <= (i_rx_d == 4'h5) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
               if (!i_rx_dv) begin
                  r_state <= S_IDLE;
               end else if (i_rx_d == 4'hD) begin
                  r_state    <= S_DATA;
                  r_half     <= 1'b0;
                  r_crc      <= 32'hFFFFFFFF;
                  r_fill     <= 3'd0;
                  r_byte_cnt <= 11'd0;
                  r_er       <= 1'b0;
               end else if (i_rx_d != 4'h5) begin
                  r_state <= S_DROP;
               end
            end
            S_DATA: begin
               if (!i_rx_dv) begin
                  r_state <= S_IDLE;
                  if (w_line_full) begin
                     o_valid <= 1'b1;
                     o_last  <= 1'b1;
                     o_error <= w_bad_end;
                     o_data  <= r_line[4];
                  end
                  if (w_bad_end)
                     o_error_count <= o_error_count + 16'd1;
                  else
                     o_frame_count <= o_frame_count + 16'd1;
               end else begin
                  if (i_rx_er)
                     r_er <= 1'b1;
                  if (!r_half) begin
                     r_low  <= i_rx_d;
                     r_half <= 1'b1;
                  end else begin
                     r_half     <= 1'b0;
                     r_crc      <= f_crc_byte(r_crc, w_byte);
                     r_byte_cnt <= w_byte_cnt_nxt;
                     r_line[0]  <= w_byte;
                     for (int i = 1; i < 5; i++)
                        r_line[i] <= r_line[i-1];
                     if (!w_line_full)
                        r_fill <= r_fill + 3'd1;
                     if (w_line_full) begin
                        o_valid <= 1'b1;
                        o_data  <= r_line[4];
                     end
                     // Oversized: close the frame on the byte that would be emitted anyway.
                     if (w_byte_cnt_nxt == LP_MAX_P1) begin
                        o_last        <= 1'b1;
                        o_error       <= 1'b1;
                        o_error_count <= o_error_count + 16'd1;
                        r_state       <= S_DROP;
                     end
                  end
               end
            end
            S_DROP: begin
               if (!i_rx_dv)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mii_rx_frame_receiver.sv
// Randomized frames driven nibble-wise; expected payload, error flags and counters come from a frame-level model.
module tb_mii_rx_frame_receiver;

   localparam int MINB = 64;
   localparam int MAXB = 1518;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rx_d = 4'h0;
   logic        rx_dv = 1'b0;
   logic        rx_er = 1'b0;
   logic [7:0]  o_data;
   logic        o_valid, o_last, o_error;
   logic [15:0] o_frame_count, o_error_count;

   mii_rx_frame_receiver #(.P_MIN_FRAME_BYTES(MINB), .P_MAX_FRAME_BYTES(MAXB)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_rx_d(rx_d), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
      .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_error(o_error),
      .o_frame_count(o_frame_count), .o_error_count(o_error_count));

   always #20 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] fr_q[$];
   logic [9:0] exp_q[$];
   logic [9:0] rx_q[$];
   int exp_frames = 0, exp_errs = 0, vld_cnt = 0, last_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         rx_q.push_back({o_last, o_last & o_error, o_data});
         vld_cnt++;
         if (o_last) last_cnt++;
      end
   end

   // Ethernet FCS of the first n frame bytes, as it appears on the wire (complemented, LSB first).
   function automatic logic [31:0] ref_fcs(input int n);
      logic [31:0] c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c ^= {24'd0, fr_q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build_frame(input int n, input bit arp, input bit good_fcs);
      logic [31:0] f;
      fr_q.delete();
      if (n < 4) begin
         for (int i = 0; i < n; i++) fr_q.push_back(8'($urandom));
      end else begin
         for (int i = 0; i < n - 4; i++) fr_q.push_back(8'($urandom));
         if (arp) begin
            for (int i = 0; i < 6; i++) fr_q[i] = 8'hFF;
            fr_q[12] = 8'h08;
            fr_q[13] = 8'h06;
         end
         f = ref_fcs(n - 4);
         for (int i = 0; i < 4; i++) fr_q.push_back(f[8*i +: 8]);
         if (!good_fcs)
            fr_q[n - 1 - $urandom_range(0, 3)] ^= ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'h0F;
      end
   endtask

   task automatic model(input bit er, input bit odd);
      int n = fr_q.size();
      bit bad;
      if (n > MAXB) begin
         for (int i = 0; i < MAXB - 4; i++)
            exp_q.push_back({(i == MAXB - 5), (i == MAXB - 5), fr_q[i]});
         exp_errs++;
         return;
      end
      bad = er || odd || (n < MINB) || (n <= 4);
      if (n >= 4 && {fr_q[n-1], fr_q[n-2], fr_q[n-3], fr_q[n-4]} != ref_fcs(n - 4)) bad = 1'b1;
      for (int i = 0; i < n - 4; i++)
         exp_q.push_back({(i == n - 5), (i == n - 5) && bad, fr_q[i]});
      if (bad) exp_errs++; else exp_frames++;
   endtask

   task automatic drive_nib(input logic [3:0] n, input logic er);
      @(negedge clk);
      rx_dv = 1'b1; rx_d = n; rx_er = er;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_dv = 1'b0; rx_d = 4'h0; rx_er = 1'b0;
      end
   endtask

   task automatic send(input int er_nib, input bit odd, input logic [3:0] pre_bad);
      int k = 0;
      for (int i = 0; i < 15; i++) drive_nib((pre_bad != 4'h0 && i == 7) ? pre_bad : 4'h5, 1'b0);
      drive_nib(4'hD, 1'b0);
      foreach (fr_q[i]) begin
         drive_nib(fr_q[i][3:0], k == er_nib); k++;
         drive_nib(fr_q[i][7:4], k == er_nib); k++;
      end
      if (odd) drive_nib(4'($urandom), 1'b0);
   endtask

   task automatic check_q(input string tag);
      int m;
      chk({tag, "_len"}, rx_q.size(), exp_q.size());
      m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk($sformatf("%s[%0d]", tag, i), rx_q[i], exp_q[i]);
      chk({tag, "_frames"}, o_frame_count, 16'(exp_frames));
      chk({tag, "_errs"}, o_error_count, 16'(exp_errs));
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic frame(input string tag, input int n, input bit arp, input bit good,
                        input int er_nib, input bit odd);
      build_frame(n, arp, good);
      send(er_nib, odd, 4'h0);
      model(er_nib >= 0, odd);
      idle(8);
      check_q(tag);
   endtask

   initial begin
      int v0, lc;
      repeat (3) @(negedge clk);
      chk("rst_data", o_data, 8'h00);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_last", o_last, 1'b0);
      chk("rst_error", o_error, 1'b0);
      chk("rst_frames", o_frame_count, 16'd0);
      chk("rst_errs", o_error_count, 16'd0);
      rst_n = 1'b1;
      idle(3);

      build_frame(64, 1'b1, 1'b1);
      send(-1, 1'b0, 4'h0);
      model(1'b0, 1'b0);
      idle(8);
      chk("arp_first", rx_q[0][7:0], 8'hFF);
      chk("arp_type", {rx_q[12][7:0], rx_q[13][7:0]}, 16'h0806);
      chk("arp_last", rx_q[59][9:8], 2'b10);
      check_q("arp");

      v0 = vld_cnt;
      build_frame(78, 1'b0, 1'b1);
      repeat (3) begin
         send(-1, 1'b0, 4'h0);
         model(1'b0, 1'b0);
         idle(32);
      end
      chk("icmp_vld", vld_cnt - v0, 3 * (78 - 4));
      check_q("icmp");

      frame("badfcs", 64, 1'b1, 1'b0, -1, 1'b0);
      frame("rxer", 64, 1'b1, 1'b1, 40, 1'b0);
      frame("odd", 64, 1'b1, 1'b1, -1, 1'b1);
      frame("short20", 20, 1'b0, 1'b1, -1, 1'b0);
      frame("tiny4", 4, 1'b0, 1'b1, -1, 1'b0);

      build_frame(64, 1'b1, 1'b1);
      send(-1, 1'b0, 4'h3);
      idle(8);
      check_q("badpre");
      frame("afterpre", 64, 1'b1, 1'b1, -1, 1'b0);

      build_frame(70, 1'b0, 1'b1);
      send(-1, 1'b0, 4'h0);
      model(1'b0, 1'b0);
      idle(1);
      build_frame(66, 1'b0, 1'b1);
      send(-1, 1'b0, 4'h0);
      model(1'b0, 1'b0);
      idle(8);
      check_q("b2b");

      for (int r = 0; r < 20; r++) begin
         build_frame($urandom_range(1, 120), 1'b0, $urandom_range(0, 3) != 0);
         send(-1, 1'b0, 4'h0);
         model(1'b0, 1'b0);
         idle($urandom_range(1, 8));
      end
      idle(8);
      check_q("rand");

      frame("max", MAXB, 1'b0, 1'b1, -1, 1'b0);
      frame("over", MAXB + 12, 1'b0, 1'b1, -1, 1'b0);

      build_frame(64, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) drive_nib(4'h5, 1'b0);
      drive_nib(4'hD, 1'b0);
      for (int k = 0; k < 60; k++) drive_nib(fr_q[k/2][4*(k%2) +: 4], 1'b0);
      lc = last_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", o_valid, 1'b0);
      chk("mrst_last", o_last, 1'b0);
      chk("mrst_frames", o_frame_count, 16'd0);
      chk("mrst_errs", o_error_count, 16'd0);
      idle(2);
      rst_n = 1'b1;
      idle(8);
      chk("mrst_nolast", last_cnt, lc);
      rx_q.delete();
      exp_q.delete();
      exp_frames = 0;
      exp_errs = 0;
      frame("postrst", 64, 1'b1, 1'b1, -1, 1'b0);
      chk("postrst_one", o_frame_count, 16'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
